// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding and the decimal digit-count helper.
package bin2bcd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // ceil(n_bits * log10(2)) in integer arithmetic (log10(2) ~= 0.30103)
    function automatic int digit_count(input int n_bits);
        return (n_bits * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit whose value is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = (din >= 4'd5) ? din + 4'd3 : din;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one bit per clock,
// Start/Ready handshake in, one-cycle Done pulse with a registered BCD result out.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int N_BITS   = 8,
    parameter int N_DIGITS = digit_count(N_BITS)
) (
    input  logic                  CLOCK_50,
    input  logic                  Resetn,
    input  logic                  Start,
    input  logic [N_BITS-1:0]     Bin,
    output logic                  Ready,
    output logic                  Done,
    output logic [4*N_DIGITS-1:0] BCD
);

    localparam int CNT_W = $clog2(N_BITS + 1);
    localparam int ACC_W = 4 * N_DIGITS;

    state_t             state, state_nxt;
    logic [N_BITS-1:0]  sr;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   bcd_r;
    logic [CNT_W-1:0]   cnt;

    logic [ACC_W-1:0]        corrected;
    logic [ACC_W+N_BITS-1:0] shifted;
    logic                    last_shift;

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (acc[4*i +: 4]),
            .dout (corrected[4*i +: 4])
        );
    end

    always_comb begin
        shifted    = {corrected, sr} << 1;
        last_shift = (cnt == CNT_W'(N_BITS - 1));
    end

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path through
    // the case statement leaves it unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (Start) state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        Ready = (state == IDLE);
        Done  = (state == DONE);
    end

    // Datapath: BCD is only loaded on the final shift, so intermediate
    // accumulator values never reach the output.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            sr    <= '0;
            acc   <= '0;
            cnt   <= '0;
            bcd_r <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        sr  <= Bin;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    acc <= shifted[ACC_W+N_BITS-1:N_BITS];
                    sr  <= shifted[N_BITS-1:0];
                    cnt <= cnt + 1'b1;
                    if (last_shift) bcd_r <= shifted[ACC_W+N_BITS-1:N_BITS];
                end
                default: ;
            endcase
        end
    end

    assign BCD = bcd_r;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a driver pushes decimal-digit expectations,
// a monitor pops and compares on every Done pulse.
module tb_bin2bcd_seq;

    localparam int N_BITS   = 8;
    localparam int N_DIGITS = 3;
    localparam int BW       = 4 * N_DIGITS;

    logic              CLOCK_50 = 1'b0;
    logic              Resetn   = 1'b0;
    logic              Start    = 1'b0;
    logic [N_BITS-1:0] Bin      = '0;
    logic              Ready;
    logic              Done;
    logic [BW-1:0]     BCD;

    int vectors     = 0;
    int miscompares = 0;

    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] hold_ref = '0;
    logic          rst_q    = 1'b1;
    int            cyc      = 0;
    int            last_done = -1;
    bit            spacing_on = 1'b0;

    bin2bcd_seq #(.N_BITS(N_BITS), .N_DIGITS(N_DIGITS)) dut (
        .CLOCK_50 (CLOCK_50),
        .Resetn   (Resetn),
        .Start    (Start),
        .Bin      (Bin),
        .Ready    (Ready),
        .Done     (Done),
        .BCD      (BCD)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: decimal digits by plain division.
    function automatic logic [BW-1:0] ref_bcd(input int v);
        logic [BW-1:0] r;
        int rem;
        r   = '0;
        rem = v;
        for (int d = 0; d < N_DIGITS; d++) begin
            r[4*d +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge CLOCK_50) begin
        cyc++;
        rst_q <= !Resetn;
    end

    // Monitor / scoreboard
    always @(negedge CLOCK_50) begin
        if (rst_q) hold_ref = '0;
        if (!spacing_on) last_done = -1;
        if (Done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", int'(Done), 0);
            end else begin
                logic [BW-1:0] e;
                e = exp_q.pop_front();
                check("bcd", int'(BCD), int'(e));
                for (int d = 0; d < N_DIGITS; d++)
                    check("digit_le9", int'(BCD[4*d +: 4] <= 4'd9), 1);
                hold_ref = e;
                if (spacing_on) begin
                    if (last_done >= 0) check("done_spacing", cyc - last_done, 10);
                    last_done = cyc;
                end
            end
        end else if (BCD !== hold_ref) begin
            check("bcd_hold", int'(BCD), int'(hold_ref));
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!Ready && n < 30) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (!Ready) check("ready_timeout", int'(Ready), 1);
    endtask

    // Counts cycles from the capture edge until Done, then checks Ready follows.
    task automatic wait_done_latency(input int want);
        int j = 0;
        while (!Done && j < 30) begin
            @(negedge CLOCK_50);
            j++;
        end
        check("done_latency", j, want);
        @(negedge CLOCK_50);
        check("ready_after_done", int'(Ready), 1);
        check("done_one_cycle", int'(Done), 0);
    endtask

    task automatic convert(input logic [N_BITS-1:0] v);
        wait_ready();
        Start = 1'b1;
        Bin   = v;
        exp_q.push_back(ref_bcd(int'(v)));
        @(negedge CLOCK_50);
        Start = 1'b0;
        Bin   = N_BITS'($urandom);
        wait_done_latency(N_BITS);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    initial begin
        logic [N_BITS-1:0] dir_vals[5];
        dir_vals = '{8'd0, 8'd255, 8'd99, 8'd100, 8'd9};

        // Reset state
        idle(3);
        check("reset_ready", int'(Ready), 1);
        check("reset_done", int'(Done), 0);
        check("reset_bcd", int'(BCD), 0);
        Resetn = 1'b1;
        idle(1);

        // Directed values, including the zero-operand latency case
        foreach (dir_vals[i]) convert(dir_vals[i]);

        // Start pulsed mid-conversion must be ignored
        wait_ready();
        Start = 1'b1;
        Bin   = 8'd200;
        exp_q.push_back(ref_bcd(200));
        @(negedge CLOCK_50);
        Start = 1'b0;
        idle(2);
        Start = 1'b1;
        Bin   = 8'd17;
        @(negedge CLOCK_50);
        Start = 1'b0;
        begin
            int j = 3;
            while (!Done && j < 30) begin
                @(negedge CLOCK_50);
                j++;
            end
            check("ignored_start_latency", j, N_BITS);
        end
        idle(15);

        // Reset mid-conversion aborts with no Done and clears BCD
        wait_ready();
        Start = 1'b1;
        Bin   = 8'd123;
        @(negedge CLOCK_50);
        Start = 1'b0;
        idle(3);
        Resetn = 1'b0;
        Start  = 1'b1;
        @(negedge CLOCK_50);
        check("abort_ready", int'(Ready), 1);
        check("abort_bcd", int'(BCD), 0);
        check("abort_done", int'(Done), 0);
        Start  = 1'b0;
        Resetn = 1'b1;
        idle(15);
        check("abort_no_done_bcd", int'(BCD), 0);

        // Start held high: exhaustive back-to-back sweep with spacing check
        spacing_on = 1'b1;
        Start = 1'b1;
        for (int v = 0; v < (1 << N_BITS); v++) begin
            wait_ready();
            Bin = N_BITS'(v);
            exp_q.push_back(ref_bcd(v));
            @(negedge CLOCK_50);
        end
        Start = 1'b0;
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 30) begin
                @(negedge CLOCK_50);
                n++;
            end
        end
        spacing_on = 1'b0;

        // Random operands with random idle gaps
        for (int i = 0; i < 40; i++) begin
            convert(N_BITS'($urandom));
            idle(int'($urandom_range(0, 3)));
        end

        idle(12);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
